// File: rtl/lut_layer_scheduler.sv
// Time-multiplexed LogicNets layer: one shared truth-table store, one neuron evaluated per cycle.
// Optional perf counters (perf_frames, perf_stall) are built when LUTSCHED_PERF_EN is defined.
module lut_layer_scheduler #(
   parameter int unsigned IN_WIDTH = 16,
   parameter int unsigned NEURONS  = 8,
   parameter int unsigned FANIN    = 6,
   parameter int unsigned IDX_W    = $clog2(IN_WIDTH),
   parameter int unsigned NID_W    = $clog2(NEURONS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_WIDTH-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NEURONS-1:0]  out_data,
   input  logic                cfg_we,
   output logic                cfg_ready,
   input  logic                cfg_sel,
   input  logic [NID_W-1:0]    cfg_neuron,
   input  logic [FANIN-1:0]    cfg_addr,
   input  logic [IDX_W-1:0]    cfg_data,
   output logic                cfg_err,
   output logic                busy
`ifdef LUTSCHED_PERF_EN
   ,
   output logic [31:0]         perf_frames,
   output logic [31:0]         perf_stall
`endif
);

   localparam int unsigned TT_DEPTH = 2 ** FANIN;
   localparam int unsigned SLOT_W   = $clog2(FANIN);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StEval = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [NID_W-1:0] LastNeuron = NID_W'(NEURONS - 1);
   localparam logic [NID_W:0]   NeuronsLim = (NID_W + 1)'(NEURONS);
   localparam logic [SLOT_W:0]  FaninLim   = (SLOT_W + 1)'(FANIN);
   localparam logic [IDX_W:0]   InWidthLim = (IDX_W + 1)'(IN_WIDTH);

   logic [1:0]          state_q, state_d;
   logic [NID_W-1:0]    cnt_q, cnt_d;
   logic [IN_WIDTH-1:0] in_reg_q, in_reg_d;
   logic [NEURONS-1:0]  out_data_q, out_data_d;
   logic                cfg_err_q, cfg_err_d;

   logic [TT_DEPTH-1:0] tt_q  [NEURONS];
   logic [IDX_W-1:0]    idx_q [NEURONS][FANIN];

   logic [FANIN-1:0]    addr;
   logic [SLOT_W-1:0]   cfg_slot;
   logic                cfg_fire;
   logic                cfg_bad;
   logic                tt_we;
   logic                idx_we;

   // Gather the current neuron's fan-in bits; slot 0 is the table address LSB.
   always_comb begin
      addr = '0;
      for (int k = 0; k < FANIN; k++) begin
         addr[k] = in_reg_q[idx_q[cnt_q][k]];
      end
   end

   assign cfg_slot = cfg_addr[SLOT_W-1:0];
   assign cfg_fire = cfg_we && (state_q == StIdle);

   always_comb begin
      cfg_bad = ({1'b0, cfg_neuron} >= NeuronsLim);
      if (cfg_sel) begin
         cfg_bad = cfg_bad || ({1'b0, cfg_slot} >= FaninLim) || ({1'b0, cfg_data} >= InWidthLim);
      end
   end

   assign tt_we     = cfg_fire && !cfg_sel && !cfg_bad;
   assign idx_we    = cfg_fire && cfg_sel && !cfg_bad;
   assign cfg_err_d = cfg_fire && cfg_bad;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      in_reg_d   = in_reg_q;
      out_data_d = out_data_q;
      unique case (state_q)
         StIdle: begin
            // A config write in the same cycle takes priority over the input.
            if (in_valid && !cfg_we) begin
               in_reg_d = in_data;
               cnt_d    = '0;
               state_d  = StEval;
            end
         end
         StEval: begin
            out_data_d[cnt_q] = tt_q[cnt_q][addr];
            cnt_d             = cnt_q + 1'b1;
            if (cnt_q == LastNeuron) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         in_reg_q   <= '0;
         out_data_q <= '0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         in_reg_q   <= in_reg_d;
         out_data_q <= out_data_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   // Fan-in wiring returns to the identity-like default on every reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NEURONS; n++) begin
            for (int k = 0; k < FANIN; k++) begin
               idx_q[n][k] <= IDX_W'(k % IN_WIDTH);
            end
         end
      end else if (idx_we) begin
         idx_q[cfg_neuron][cfg_slot] <= cfg_data;
      end
   end

   // Truth tables survive reset; they are only changed by accepted writes.
   always_ff @(posedge clk) begin
      if (!rst && tt_we) begin
         tt_q[cfg_neuron][cfg_addr] <= cfg_data[0];
      end
   end

   assign in_ready  = (state_q == StIdle) && !cfg_we;
   assign cfg_ready = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign out_data  = out_data_q;
   assign cfg_err   = cfg_err_q;
   assign busy      = (state_q != StIdle);

`ifdef LUTSCHED_PERF_EN
   logic [31:0] perf_frames_q;
   logic [31:0] perf_stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_frames_q <= '0;
         perf_stall_q  <= '0;
      end else if (state_q == StDone) begin
         if (out_ready) begin
            perf_frames_q <= perf_frames_q + 32'd1;
         end else begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_frames = perf_frames_q;
   assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Directed bench for lut_layer_scheduler: default instance plus a small odd-sized one
// (IN_WIDTH=12, NEURONS=5) where out-of-range neuron and index writes are encodable.
module tb_lut_layer_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] in_data;
   logic [7:0]  out_data;
   logic        cfg_we, cfg_ready, cfg_sel, cfg_err, busy;
   logic [2:0]  cfg_neuron;
   logic [5:0]  cfg_addr;
   logic [3:0]  cfg_data;

   logic        in2_valid, in2_ready, out2_valid, out2_ready;
   logic [11:0] in2_data;
   logic [4:0]  out2_data;
   logic        c2_we, c2_ready, c2_sel, c2_err, busy2;
   logic [2:0]  c2_neuron;
   logic [5:0]  c2_addr;
   logic [3:0]  c2_data;

`ifdef LUTSCHED_PERF_EN
   logic [31:0] perf_frames, perf_stall, perf2_frames, perf2_stall;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lut_layer_scheduler u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .cfg_we(cfg_we),
      .cfg_ready(cfg_ready), .cfg_sel(cfg_sel), .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .cfg_err(cfg_err), .busy(busy)
`ifdef LUTSCHED_PERF_EN
      , .perf_frames(perf_frames), .perf_stall(perf_stall)
`endif
   );

   lut_layer_scheduler #(.IN_WIDTH(12), .NEURONS(5)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in2_valid), .in_ready(in2_ready), .in_data(in2_data),
      .out_valid(out2_valid), .out_ready(out2_ready), .out_data(out2_data), .cfg_we(c2_we),
      .cfg_ready(c2_ready), .cfg_sel(c2_sel), .cfg_neuron(c2_neuron), .cfg_addr(c2_addr),
      .cfg_data(c2_data), .cfg_err(c2_err), .busy(busy2)
`ifdef LUTSCHED_PERF_EN
      , .perf_frames(perf2_frames), .perf_stall(perf2_stall)
`endif
   );

   typedef struct {
      logic [15:0] din;
      logic [7:0]  dout;
   } vec_t;

   typedef struct {
      logic       sel;
      logic [2:0] neuron;
      logic [5:0] addr;
      logic [3:0] data;
   } rej_t;

   vec_t vecs[10];
   rej_t rej2[5];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cfg_wr(input logic sel, input int n, input int a, input int d);
      cfg_we     = 1'b1;
      cfg_sel    = sel;
      cfg_neuron = 3'(n);
      cfg_addr   = 6'(a);
      cfg_data   = 4'(d);
      step();
      cfg_we = 1'b0;
   endtask

   task automatic cfg2_wr(input logic sel, input int n, input int a, input int d);
      c2_we     = 1'b1;
      c2_sel    = sel;
      c2_neuron = 3'(n);
      c2_addr   = 6'(a);
      c2_data   = 4'(d);
      step();
      c2_we = 1'b0;
   endtask

   // Accepts one vector, checks latency and result; returns in DONE when out_ready is low.
   task automatic run_frame(input string nm, input logic [15:0] d, input logic [7:0] exp);
      int lat = 0;
      int w = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && w < 20) begin
         step();
         w++;
      end
      chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      while (!out_valid && lat < 30) begin
         step();
         lat++;
      end
      chk({nm, " latency"}, 64'(lat), 64'd8);
      chk({nm, " out_data"}, 64'(out_data), 64'(exp));
      if (out_ready) begin
         step();
         chk({nm, " out_valid drop"}, 64'(out_valid), 64'd0);
      end
   endtask

   initial begin
      int lat;
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      cfg_we = 1'b0; cfg_sel = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
      in2_valid = 1'b0; in2_data = '0; out2_ready = 1'b1;
      c2_we = 1'b0; c2_sel = 1'b0; c2_neuron = '0; c2_addr = '0; c2_data = '0;

      vecs[0] = '{16'h0003, 8'h01};
      vecs[1] = '{16'h0001, 8'h00};
      vecs[2] = '{16'hFC00, 8'h08};
      vecs[3] = '{16'hFC03, 8'h09};
      vecs[4] = '{16'hFFFF, 8'h08};
      vecs[5] = '{16'h7C03, 8'h01};
      vecs[6] = '{16'h0020, 8'h80};
      vecs[7] = '{16'hFC20, 8'h88};
      vecs[8] = '{16'h0100, 8'h20};
      vecs[9] = '{16'h0103, 8'h01};

      rej2[0] = '{1'b0, 3'd5, 6'd0,  4'd1};
      rej2[1] = '{1'b0, 3'd7, 6'd3,  4'd1};
      rej2[2] = '{1'b1, 3'd0, 6'd0,  4'd12};
      rej2[3] = '{1'b1, 3'd0, 6'd0,  4'd15};
      rej2[4] = '{1'b1, 3'd2, 6'd6,  4'd3};

      step();
      step();
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset out_data", 64'(out_data), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset cfg_err", 64'(cfg_err), 64'd0);
      rst = 1'b0;
      #1;
      chk("idle in_ready", 64'(in_ready), 64'd1);
      chk("idle cfg_ready", 64'(cfg_ready), 64'd1);

      for (int n = 0; n < 8; n++) begin
         for (int a = 0; a < 64; a++) cfg_wr(1'b0, n, a, 0);
      end
      cfg_wr(1'b0, 0, 3, 1);
      for (int k = 0; k < 6; k++) cfg_wr(1'b1, 3, k, 15 - k);
      cfg_wr(1'b0, 3, 63, 1);
      cfg_wr(1'b0, 7, 32, 1);
      cfg_wr(1'b1, 5, 0, 8);
      cfg_wr(1'b0, 5, 1, 1);
      chk("valid write cfg_err", 64'(cfg_err), 64'd0);

      for (int i = 0; i < 10; i++) begin
         run_frame($sformatf("vec%0d", i), vecs[i].din, vecs[i].dout);
      end

      // Config and input in the same IDLE cycle: config wins, input waits one cycle.
      in_data = 16'h0000; in_valid = 1'b1;
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_neuron = 3'd2; cfg_addr = 6'd0; cfg_data = 4'd1;
      #1;
      chk("collide cfg_ready", 64'(cfg_ready), 64'd1);
      chk("collide in_ready", 64'(in_ready), 64'd0);
      step();
      cfg_we = 1'b0;
      #1;
      chk("collide not taken", 64'(busy), 64'd0);
      chk("collide in_ready next", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      chk("collide accepted", 64'(busy), 64'd1);
      lat = 0;
      while (!out_valid && lat < 30) begin
         step();
         lat++;
      end
      chk("collide latency", 64'(lat), 64'd8);
      chk("collide out_data", 64'(out_data), 64'h04);
      step();

      // Reset restores default wiring; then stall in DONE for five cycles.
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b0;
      run_frame("stall", 16'h0003, 8'h01);
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_neuron = 3'd1; cfg_addr = 6'd0; cfg_data = 4'd1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall%0d out_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("stall%0d out_data", i), 64'(out_data), 64'h01);
         chk($sformatf("stall%0d in_ready", i), 64'(in_ready), 64'd0);
         chk($sformatf("stall%0d cfg_ready", i), 64'(cfg_ready), 64'd0);
         step();
         chk($sformatf("stall%0d cfg_err", i), 64'(cfg_err), 64'd0);
      end
      cfg_we = 1'b0;
      out_ready = 1'b1;
      step();
      chk("release out_valid", 64'(out_valid), 64'd0);
      chk("release busy", 64'(busy), 64'd0);
`ifdef LUTSCHED_PERF_EN
      chk("perf_stall", 64'(perf_stall), 64'd5);
      chk("perf_frames", 64'(perf_frames), 64'd1);
`endif

      // Rejected slot writes pulse cfg_err once and change nothing.
      for (int s = 6; s < 8; s++) begin
         cfg_wr(1'b1, 0, s, 9);
         chk($sformatf("slot%0d cfg_err", s), 64'(cfg_err), 64'd1);
         step();
         chk($sformatf("slot%0d cfg_err drop", s), 64'(cfg_err), 64'd0);
      end
      run_frame("post-reject", 16'h0003, 8'h01);
      run_frame("busy-write dropped", 16'h0000, 8'h04);

      // Abort mid-EVAL; the remap of neuron 0 must be undone by reset.
      cfg_wr(1'b1, 0, 0, 9);
      in_data = 16'h0003; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("abort pre out_data", 64'(out_data[0]), 64'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("abort out_valid", 64'(out_valid), 64'd0);
      chk("abort out_data", 64'(out_data), 64'd0);
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort in_ready", 64'(in_ready), 64'd1);
      run_frame("after abort", 16'h0003, 8'h01);

      // Odd-sized instance: neuron and index range checks.
      for (int n = 0; n < 5; n++) begin
         for (int a = 0; a < 64; a++) cfg2_wr(1'b0, n, a, 0);
      end
      cfg2_wr(1'b0, 0, 1, 1);
      cfg2_wr(1'b0, 1, 1, 1);
      for (int i = 0; i < 5; i++) begin
         cfg2_wr(rej2[i].sel, int'(rej2[i].neuron), int'(rej2[i].addr), int'(rej2[i].data));
         chk($sformatf("rej2_%0d cfg_err", i), 64'(c2_err), 64'd1);
         step();
         chk($sformatf("rej2_%0d cfg_err drop", i), 64'(c2_err), 64'd0);
      end
      cfg2_wr(1'b1, 1, 0, 11);
      chk("dut2 valid idx cfg_err", 64'(c2_err), 64'd0);
      for (int v = 0; v < 2; v++) begin
         in2_data = (v == 0) ? 12'h001 : 12'h800;
         in2_valid = 1'b1;
         step();
         in2_valid = 1'b0;
         lat = 0;
         while (!out2_valid && lat < 30) begin
            step();
            lat++;
         end
         chk($sformatf("dut2 frame%0d latency", v), 64'(lat), 64'd5);
         chk($sformatf("dut2 frame%0d out_data", v), 64'(out2_data),
             (v == 0) ? 64'h01 : 64'h02);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
